// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: default datapath widths and the
// ALU op encodings driven onto alu_op.
package alu_issue_stage_pkg;

    localparam int unsigned DataWDefault  = 32;
    localparam int unsigned RegAwDefault  = 5;
    localparam int unsigned OpWDefault    = 3;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpNot = 3'b100,
        OpSlt = 3'b101
    } alu_op_e;

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Per-operand forwarding select used when the issue stage captures an
// instruction.
//   src_addr_i             source register number
//   rf_val_i               register-file read data
//   own_en_i/own_rd_i/own_val_i  instruction leaving this stage this cycle
//   mem_*/wb_*             memory and writeback producers
//   val_o                  resolved operand value
// Priority: r0 -> 0, then own stage, memory, writeback, register file.
module alu_issue_stage_fwd_mux
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DataW = DataWDefault,
    parameter int unsigned RegAw = RegAwDefault
) (
    input  logic [RegAw-1:0] src_addr_i,
    input  logic [DataW-1:0] rf_val_i,
    input  logic             own_en_i,
    input  logic [RegAw-1:0] own_rd_i,
    input  logic [DataW-1:0] own_val_i,
    input  logic             mem_en_i,
    input  logic [RegAw-1:0] mem_rd_i,
    input  logic [DataW-1:0] mem_val_i,
    input  logic             wb_en_i,
    input  logic [RegAw-1:0] wb_rd_i,
    input  logic [DataW-1:0] wb_val_i,
    output logic [DataW-1:0] val_o
);

    always_comb begin
        val_o = rf_val_i;
        if (src_addr_i == '0) begin
            val_o = '0;
        end else if (own_en_i && (own_rd_i == src_addr_i)) begin
            val_o = own_val_i;
        end else if (mem_en_i && (mem_rd_i == src_addr_i)) begin
            val_o = mem_val_i;
        end else if (wb_en_i && (wb_rd_i == src_addr_i)) begin
            val_o = wb_val_i;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Pipeline register in front of the 32-bit ALU. Captures decoded instructions
// over a valid/ready handshake, resolving operand forwarding at capture, and
// holds op/operands/destination until the memory stage accepts.
//   clk, rst_n                 clock, synchronous active-low reset
//   in_*                       decode-side handshake and instruction fields
//   flush                      squash held and incoming instruction
//   mem_*, wb_*                downstream producers for forwarding
//   alu_op/alu_num1/alu_num2   registered ALU inputs
//   alu_result/alu_zero        ALU outputs, passed through to out_*
//   out_*                      memory-side handshake and destination info
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned REG_AW = RegAwDefault,
    parameter int unsigned OP_W   = OpWDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [DATA_W-1:0] in_rs1_val,
    input  logic [DATA_W-1:0] in_rs2_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_reg_write,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_result,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write
);

    logic              valid_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] num1_q;
    logic [DATA_W-1:0] num2_q;
    logic [REG_AW-1:0] rd_q;
    logic              rw_q;

    logic              accept;
    logic              out_fire;
    logic              own_fwd_en;
    logic [DATA_W-1:0] rs1_fwd;
    logic [DATA_W-1:0] rs2_fwd;

    // in_ready deliberately ignores in_valid to avoid a combinational loop
    // with decode.
    assign in_ready   = !flush && (!valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_fire   = valid_q && out_ready;
    // Only an instruction actually leaving this cycle may forward its result;
    // stale destination regs after a drain must not match.
    assign own_fwd_en = out_fire && rw_q;

    alu_issue_stage_fwd_mux #(
        .DataW (DATA_W),
        .RegAw (REG_AW)
    ) u_fwd_rs1 (
        .src_addr_i (in_rs1_addr),
        .rf_val_i   (in_rs1_val),
        .own_en_i   (own_fwd_en),
        .own_rd_i   (rd_q),
        .own_val_i  (alu_result),
        .mem_en_i   (mem_reg_write),
        .mem_rd_i   (mem_rd_addr),
        .mem_val_i  (mem_result),
        .wb_en_i    (wb_reg_write),
        .wb_rd_i    (wb_rd_addr),
        .wb_val_i   (wb_result),
        .val_o      (rs1_fwd)
    );

    alu_issue_stage_fwd_mux #(
        .DataW (DATA_W),
        .RegAw (REG_AW)
    ) u_fwd_rs2 (
        .src_addr_i (in_rs2_addr),
        .rf_val_i   (in_rs2_val),
        .own_en_i   (own_fwd_en),
        .own_rd_i   (rd_q),
        .own_val_i  (alu_result),
        .mem_en_i   (mem_reg_write),
        .mem_rd_i   (mem_rd_addr),
        .mem_val_i  (mem_result),
        .wb_en_i    (wb_reg_write),
        .wb_rd_i    (wb_rd_addr),
        .wb_val_i   (wb_result),
        .val_o      (rs2_fwd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            num1_q  <= '0;
            num2_q  <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            // Covers simultaneous dequeue/enqueue for full throughput.
            valid_q <= 1'b1;
            op_q    <= in_op;
            num1_q  <= rs1_fwd;
            num2_q  <= in_use_imm ? in_imm : rs2_fwd;
            rd_q    <= in_rd_addr;
            rw_q    <= in_reg_write;
        end else if (out_fire) begin
            valid_q <= 1'b0;
        end
    end

    assign alu_op        = op_q;
    assign alu_num1      = num1_q;
    assign alu_num2      = num2_q;
    assign out_valid     = valid_q;
    assign out_result    = alu_result;
    assign out_zero      = alu_zero;
    assign out_rd_addr   = rd_q;
    assign out_reg_write = rw_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs1_addr, in_rs2_addr;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic        in_use_imm;
    logic [4:0]  in_rd_addr;
    logic        in_reg_write;
    logic        flush;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic [2:0]  alu_op;
    logic [31:0] alu_num1, alu_num2, alu_result;
    logic        alu_zero;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;

    alu_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_rs1_addr   (in_rs1_addr),
        .in_rs2_addr   (in_rs2_addr),
        .in_rs1_val    (in_rs1_val),
        .in_rs2_val    (in_rs2_val),
        .in_imm        (in_imm),
        .in_use_imm    (in_use_imm),
        .in_rd_addr    (in_rd_addr),
        .in_reg_write  (in_reg_write),
        .flush         (flush),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .alu_op        (alu_op),
        .alu_num1      (alu_num1),
        .alu_num2      (alu_num2),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_rd_addr   (out_rd_addr),
        .out_reg_write (out_reg_write)
    );

    // Environment ALU fed by the DUT's registered op/operands.
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            3'b000:  alu_result = alu_num1 + alu_num2;
            3'b001:  alu_result = alu_num1 - alu_num2;
            3'b010:  alu_result = alu_num1 & alu_num2;
            3'b011:  alu_result = alu_num1 | alu_num2;
            3'b100:  alu_result = ~alu_num1;
            3'b101:  alu_result = {31'h0, $signed(alu_num1) < $signed(alu_num2)};
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [4:0]  rs1, rs2;
        logic [31:0] r1v, r2v, imm;
        logic        ui;
        logic [4:0]  rd;
        logic        rw, fl, ordy;
        logic [4:0]  mrd;
        logic        mrw;
        logic [31:0] mv;
        logic [4:0]  wrd;
        logic        wrw;
        logic [31:0] wv;
        logic        e_rdy, e_ov;
        logic [2:0]  e_op;
        logic [31:0] e_n1, e_n2, e_res;
        logic        e_zero;
        logic [4:0]  e_rd;
        logic        e_rw;
    } vec_t;

    vec_t vecs[$];
    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_op = 0; in_rs1_addr = 0; in_rs2_addr = 0;
        in_rs1_val = 0; in_rs2_val = 0; in_imm = 0; in_use_imm = 0;
        in_rd_addr = 0; in_reg_write = 0; flush = 0; out_ready = 0;
        mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    task automatic check_regs(input string tag, input int idx, input logic ov,
                              input logic [2:0] op, input logic [31:0] n1,
                              input logic [31:0] n2, input logic [4:0] rd,
                              input logic rw);
        chk({tag, " out_valid"}, idx, {31'h0, out_valid}, {31'h0, ov});
        chk({tag, " alu_op"}, idx, {29'h0, alu_op}, {29'h0, op});
        chk({tag, " alu_num1"}, idx, alu_num1, n1);
        chk({tag, " alu_num2"}, idx, alu_num2, n2);
        chk({tag, " out_rd_addr"}, idx, {27'h0, out_rd_addr}, {27'h0, rd});
        chk({tag, " out_reg_write"}, idx, {31'h0, out_reg_write}, {31'h0, rw});
    endtask

    initial begin
        // v op rs1 rs2 r1v r2v imm ui rd rw fl ordy | mrd mrw mv | wrd wrw wv |
        // e_rdy e_ov e_op e_n1 e_n2 e_res e_zero e_rd e_rw
        // 0: basic sub 10-3
        vecs.push_back('{1, 3'd1, 5'd1, 5'd2, 32'd10, 32'd3, 32'd0, 0, 5'd3, 1, 0, 1,
                         5'd0, 0, 32'd0, 5'd0, 0, 32'd0,
                         1, 1, 3'd1, 32'd10, 32'd3, 32'd7, 0, 5'd3, 1});
        // 1: I1 add 4+6 -> r5
        vecs.push_back('{1, 3'd0, 5'd1, 5'd2, 32'd4, 32'd6, 32'd0, 0, 5'd5, 1, 0, 1,
                         5'd0, 0, 32'd0, 5'd0, 0, 32'd0,
                         1, 1, 3'd0, 32'd4, 32'd6, 32'd10, 0, 5'd5, 1});
        // 2: I2 r5+r5, own stage wins over mem/wb (99)
        vecs.push_back('{1, 3'd0, 5'd5, 5'd5, 32'h11, 32'h22, 32'd0, 0, 5'd6, 1, 0, 1,
                         5'd5, 1, 32'd99, 5'd5, 1, 32'd99,
                         1, 1, 3'd0, 32'd10, 32'd10, 32'd20, 0, 5'd6, 1});
        // 3: mem beats wb on rs1, rs2 from register file
        vecs.push_back('{1, 3'd3, 5'd7, 5'd8, 32'h100, 32'h200, 32'd0, 0, 5'd7, 0, 0, 1,
                         5'd7, 1, 32'd1, 5'd7, 1, 32'd2,
                         1, 1, 3'd3, 32'd1, 32'h200, 32'h201, 0, 5'd7, 0});
        // 4: r0 sources always zero
        vecs.push_back('{1, 3'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0,
                         5'd0, 0, 0, 1,
                         5'd0, 1, 32'hFFFF_FFFF, 5'd0, 1, 32'hFFFF_FFFF,
                         1, 1, 3'd2, 32'd0, 32'd0, 32'd0, 1, 5'd0, 0});
        // 5: slt, rs1 from mem (-1), num2 immediate 3
        vecs.push_back('{1, 3'd5, 5'd9, 5'd9, 32'd5, 32'h77, 32'd3, 1, 5'd4, 1, 0, 1,
                         5'd9, 1, 32'hFFFF_FFFF, 5'd0, 0, 32'd0,
                         1, 1, 3'd5, 32'hFFFF_FFFF, 32'd3, 32'd1, 0, 5'd4, 1});
        // 6: not; mem match gated by reg_write=0, rs2 from wb
        vecs.push_back('{1, 3'd4, 5'd10, 5'd11, 32'h0F0F_0F0F, 32'd1, 32'd0, 0, 5'd12, 1,
                         0, 1,
                         5'd10, 0, 32'hDEAD, 5'd11, 1, 32'hABCD,
                         1, 1, 3'd4, 32'h0F0F_0F0F, 32'hABCD, 32'hF0F0_F0F0, 0, 5'd12, 1});
        // 7: drain, regs hold
        vecs.push_back('{0, 3'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 5'd0, 0, 0, 1,
                         5'd0, 0, 32'd0, 5'd0, 0, 32'd0,
                         1, 0, 3'd4, 32'h0F0F_0F0F, 32'hABCD, 32'hF0F0_F0F0, 0, 5'd12, 1});
        // 8: stale rd=12 must not forward when not firing
        vecs.push_back('{1, 3'd0, 5'd12, 5'd0, 32'd5, 32'd9, 32'd0, 0, 5'd1, 1, 0, 1,
                         5'd0, 0, 32'd0, 5'd0, 0, 32'd0,
                         1, 1, 3'd0, 32'd5, 32'd0, 32'd5, 0, 5'd1, 1});
        // 9-11: stall with a waiting instruction
        for (int i = 0; i < 3; i++) begin
            vecs.push_back('{1, 3'd0, 5'd13, 5'd14, 32'd100, 32'd200, 32'd0, 0, 5'd2, 1,
                             0, 0,
                             5'd0, 0, 32'd0, 5'd0, 0, 32'd0,
                             0, 1, 3'd0, 32'd5, 32'd0, 32'd5, 0, 5'd1, 1});
        end
        // 12: release, second instruction enters
        vecs.push_back('{1, 3'd0, 5'd13, 5'd14, 32'd100, 32'd200, 32'd0, 0, 5'd2, 1, 0, 1,
                         5'd0, 0, 32'd0, 5'd0, 0, 32'd0,
                         1, 1, 3'd0, 32'd100, 32'd200, 32'd300, 0, 5'd2, 1});
        // 13: drain
        vecs.push_back('{0, 3'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 5'd0, 0, 0, 1,
                         5'd0, 0, 32'd0, 5'd0, 0, 32'd0,
                         1, 0, 3'd0, 32'd100, 32'd200, 32'd300, 0, 5'd2, 1});
        // 14: rs2=2 matches stale rd but nothing fires -> register file
        vecs.push_back('{1, 3'd0, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 0, 5'd3, 1, 0, 1,
                         5'd0, 0, 32'd0, 5'd0, 0, 32'd0,
                         1, 1, 3'd0, 32'd1, 32'd2, 32'd3, 0, 5'd3, 1});
        // 15: flush with held instruction and incoming valid
        vecs.push_back('{1, 3'd1, 5'd1, 5'd2, 32'd7, 32'd8, 32'd0, 0, 5'd4, 1, 1, 0,
                         5'd0, 0, 32'd0, 5'd0, 0, 32'd0,
                         0, 0, 3'd0, 32'd1, 32'd2, 32'd3, 0, 5'd3, 1});
        // 16: after flush, ready again and nothing captured
        vecs.push_back('{0, 3'd1, 5'd1, 5'd2, 32'd7, 32'd8, 32'd0, 0, 5'd4, 1, 0, 0,
                         5'd0, 0, 32'd0, 5'd0, 0, 32'd0,
                         1, 0, 3'd0, 32'd1, 32'd2, 32'd3, 0, 5'd3, 1});

        // Reset held for 2 cycles with in_valid asserted.
        idle_inputs();
        rst_n = 0;
        in_valid = 1; in_op = 3'd1; in_rs1_val = 32'd5; in_rd_addr = 5'd9; in_reg_write = 1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        check_regs("reset", -1, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        #1;
        chk("reset in_ready", -1, {31'h0, in_ready}, 32'd1);

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = vecs[i].v; in_op = vecs[i].op;
            in_rs1_addr = vecs[i].rs1; in_rs2_addr = vecs[i].rs2;
            in_rs1_val = vecs[i].r1v; in_rs2_val = vecs[i].r2v;
            in_imm = vecs[i].imm; in_use_imm = vecs[i].ui;
            in_rd_addr = vecs[i].rd; in_reg_write = vecs[i].rw;
            flush = vecs[i].fl; out_ready = vecs[i].ordy;
            mem_rd_addr = vecs[i].mrd; mem_reg_write = vecs[i].mrw; mem_result = vecs[i].mv;
            wb_rd_addr = vecs[i].wrd; wb_reg_write = vecs[i].wrw; wb_result = vecs[i].wv;
            #1;
            chk("in_ready", i, {31'h0, in_ready}, {31'h0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            n_vec++;
            check_regs("vec", i, vecs[i].e_ov, vecs[i].e_op, vecs[i].e_n1, vecs[i].e_n2,
                       vecs[i].e_rd, vecs[i].e_rw);
            chk("out_result", i, out_result, vecs[i].e_res);
            chk("out_zero", i, {31'h0, out_zero}, {31'h0, vecs[i].e_zero});
        end

        // Reset while an instruction is held and stalled.
        @(negedge clk);
        idle_inputs();
        in_valid = 1; in_op = 3'd1; in_rs1_addr = 5'd1; in_rs2_addr = 5'd2;
        in_rs1_val = 32'd9; in_rs2_val = 32'd4; in_rd_addr = 5'd8; in_reg_write = 1;
        @(posedge clk);
        #1;
        n_vec++;
        check_regs("midreset load", -2, 1, 3'd1, 32'd9, 32'd4, 5'd8, 1);
        chk("midreset load result", -2, out_result, 32'd5);
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        @(posedge clk);
        #1;
        n_vec++;
        check_regs("midreset", -2, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("midreset in_ready", -2, {31'h0, in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline register directly upstream of the 32-bit ALU (ops add/sub/and/or/not/slt).
- Accepts decoded instructions from decode via a valid/ready handshake and resolves operand forwarding at capture time.
- Drives the ALU's op/num1/num2 from registered state; presents ALU result/zero plus destination info to the memory stage with its own valid/ready.
- Supports stall (backpressure) and flush (branch/jump squash).

Parameters:
- DATA_W, 32, datapath width (ALU operand/result width)
- REG_AW, 5, register address width; register 0 is hardwired zero
- OP_W, 3, ALU op code width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage can accept this cycle
- in_op  in  OP_W  ALU op (000 add, 001 sub, 010 and, 011 or, 100 not, 101 slt)
- in_rs1_addr, in_rs2_addr  in  REG_AW each  source register numbers
- in_rs1_val, in_rs2_val  in  DATA_W each  register-file read data
- in_imm  in  DATA_W  extended immediate
- in_use_imm  in  1  1: num2 = in_imm instead of rs2
- in_rd_addr  in  REG_AW  destination register
- in_reg_write  in  1  instruction writes rd
- flush  in  1  squash held and incoming instruction
- mem_rd_addr, mem_reg_write, mem_result  in  REG_AW/1/DATA_W  memory-stage producer
- wb_rd_addr, wb_reg_write, wb_result  in  REG_AW/1/DATA_W  writeback-stage producer
- alu_op  out  OP_W  to ALU op
- alu_num1, alu_num2  out  DATA_W each  to ALU operands
- alu_result  in  DATA_W  from ALU result
- alu_zero  in  1  from ALU zero
- out_valid  out  1  held instruction valid
- out_ready  in  1  memory stage accepts
- out_result  out  DATA_W  = alu_result
- out_zero  out  1  = alu_zero
- out_rd_addr, out_reg_write  out  REG_AW/1  held destination info

Behaviour:
- Reset (rst_n=0 at edge): out_valid=0; op/num1/num2/rd/reg_write regs=0, so alu_op=000, alu_num1=alu_num2=0, out_rd_addr=0, out_reg_write=0. Reset mid-handshake discards held instruction.
- in_ready = !flush && (!out_valid || out_ready), combinational; no in_valid->in_ready path.
- accept = in_valid && in_ready; out_fire = out_valid && out_ready.
- Edge update priority: reset > flush > accept > out_fire.
  - flush: out_valid<=0; incoming not captured.
  - accept: capture op, forwarded num1/num2, rd, reg_write; out_valid<=1 (concurrent out_fire = simultaneous dequeue/enqueue, full throughput).
  - out_fire without accept: out_valid<=0.
  - neither: hold all regs (stall); ALU outputs stable.
- Forwarding, applied only at capture, per source s in {rs1, rs2}:
  - s==0 -> 0.
  - else if out_fire && out_reg_write && out_rd_addr==s -> alu_result (own stage, leaving).
  - else if mem_reg_write && mem_rd_addr==s -> mem_result.
  - else if wb_reg_write && wb_rd_addr==s -> wb_result.
  - else register-file value.
- num2 = in_use_imm ? in_imm : forwarded rs2. num1 always forwarded rs1 (op 100 ignores num2).
- Load-use hazards are decode's responsibility (hold in_valid low); not detected here.
- Latency: 1 cycle from accept to out_valid; result combinational via ALU while held.
- No arithmetic in this block; width DATA_W throughout, no truncation.

Decomposition:
- Shared package: ALU op constants (ADD=000, SUB=001, AND=010, OR=011, NOT=100, SLT=101), DATA_W/REG_AW defaults.
- One sub-module: fwd_mux (per-operand priority select); instantiate twice.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, alu_op=000, alu_num1=alu_num2=0, in_ready=1 after release.
- Basic: accept op=001, rs1_val=10, rs2_val=3, out_ready=1 -> next cycle out_valid=1, alu_num1=10, alu_num2=3, out_result=7, out_zero=0.
- Back-to-back forward: I1 rd=5 add 4+6 then I2 rs1=5 rs2=5 op=000, out_ready=1 -> I2 captures num1=num2=10, out_result=20; mem/wb also matching rd=5 with 99 -> ignored.
- Priority and r0: mem rd=7 val=1, wb rd=7 val=2 -> num1=1; rs1=0 with all producers rd=0 val=0xFFFF_FFFF -> num1=0.
- Stall: out_ready=0 for 3 cycles -> in_ready=0, alu_num1/num2/alu_op unchanged, second instruction not captured; out_ready=1 -> both drain in order.
- Flush: held instruction plus in_valid=1 with flush=1 -> next cycle out_valid=0, in_ready=1, incoming not captured.
